// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   word_t  : 32-bit machine word
//   aluop_t : 4-bit ALU opcode
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } aluop_t;

endpackage

// File: rtl/fpga_io_pkg.sv
// Board I/O types and constants for the ALU entry harness.
//   seq_state_t : operand/opcode entry sequence state (also shown on LEDs)
//   DEBOUNCE_CYCLES_DEF : 10 ms at 50 MHz
//   KEY_* : pushbutton indices
package fpga_io_pkg;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } seq_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;

  localparam int unsigned KEY_ENTER = 0;
  localparam int unsigned KEY_BACK  = 1;
  localparam int unsigned KEY_CLEAR = 3;

endpackage

// File: rtl/key_debounce.sv
// Single pushbutton conditioner: 2-flop synchroniser, stability counter and
// a one-cycle press pulse on the debounced released-to-pressed edge.
//   CLK    : system clock
//   nRST   : asynchronous active-low reset
//   key_n  : raw active-low pushbutton
//   press  : one-cycle pulse per accepted press
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic CLK,
  input  logic nRST,
  input  logic key_n,
  output logic press
);

  logic [1:0]       sync_q;
  logic             level_q;  // debounced level, 1 = released
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      press_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        // Only the transition into the pressed (low) level generates a pulse.
        press_q <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_input_seq.sv
// Board-level ALU input stage. Synchronises switches, debounces the four
// keys, and steps through A -> B -> opcode -> execute, capturing the ALU
// result and flags.
//   CLK, nRST        : clock, async active-low reset
//   sw[16:0]         : raw switches, [15:0] data, [16] sign extension bit
//   key_n[3:0]       : raw active-low keys, [0] enter [1] back [3] clear
//   alu_out, alu_*   : combinational ALU result and flags
//   portA/portB/aluop: ALU operands and opcode
//   exec             : high for the single EXEC cycle
//   result, flags    : captured ALU output, flags = {of, zero, neg}
//   stage            : state encoding for LEDs
//   disp_word        : word for the hex displays
module alu_input_seq
  import cpu_types_pkg::*;
  import fpga_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [16:0] sw,
  input  logic [3:0]  key_n,
  input  word_t       alu_out,
  input  logic        alu_neg,
  input  logic        alu_zero,
  input  logic        alu_of,
  output word_t       portA,
  output word_t       portB,
  output aluop_t      aluop,
  output logic        exec,
  output word_t       result,
  output logic [2:0]  flags,
  output logic [2:0]  stage,
  output word_t       disp_word
);

  logic [16:0] sw_meta_q, sw_sync_q;
  logic [3:0]  press;
  word_t       sext;

  seq_state_t  state_q;
  word_t       port_a_q, port_b_q, result_q;
  aluop_t      aluop_q;
  logic [2:0]  flags_q;
  logic        exec_q;

  logic        ev_clear, ev_back, ev_enter;
  logic        unused_press;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key_debounce (
      .CLK  (CLK),
      .nRST (nRST),
      .key_n(key_n[k]),
      .press(press[k])
    );
  end

  // Key 2 has no function; it is conditioned only.
  assign unused_press = press[2];

  assign sext     = {{16{sw_sync_q[16]}}, sw_sync_q[15:0]};
  assign ev_clear = press[KEY_CLEAR];
  assign ev_back  = press[KEY_BACK];
  assign ev_enter = press[KEY_ENTER];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= LOAD_A;
      port_a_q <= '0;
      port_b_q <= '0;
      aluop_q  <= ALU_SLL;
      result_q <= '0;
      flags_q  <= '0;
      exec_q   <= 1'b0;
    end else begin
      exec_q <= 1'b0;
      if (ev_clear) begin
        // Clear wins over everything, including a pending EXEC capture.
        state_q  <= LOAD_A;
        port_a_q <= '0;
        port_b_q <= '0;
        aluop_q  <= ALU_SLL;
        result_q <= '0;
        flags_q  <= '0;
      end else begin
        unique case (state_q)
          LOAD_A: begin
            if (!ev_back && ev_enter) begin
              port_a_q <= sext;
              state_q  <= LOAD_B;
            end
          end
          LOAD_B: begin
            if (ev_back) begin
              state_q <= LOAD_A;
            end else if (ev_enter) begin
              port_b_q <= sext;
              state_q  <= LOAD_OP;
            end
          end
          LOAD_OP: begin
            if (ev_back) begin
              state_q <= LOAD_B;
            end else if (ev_enter) begin
              aluop_q <= aluop_t'(sw_sync_q[3:0]);
              state_q <= EXEC;
              exec_q  <= 1'b1;
            end
          end
          EXEC: begin
            result_q <= alu_out;
            flags_q  <= {alu_of, alu_zero, alu_neg};
            state_q  <= SHOW;
          end
          SHOW: begin
            if (ev_back) begin
              state_q <= LOAD_OP;
            end else if (ev_enter) begin
              state_q <= LOAD_A;
            end
          end
          default: state_q <= LOAD_A;
        endcase
      end
    end
  end

  always_comb begin
    disp_word = result_q;
    unique case (state_q)
      LOAD_A, LOAD_B: disp_word = sext;
      LOAD_OP:        disp_word = {28'b0, sw_sync_q[3:0]};
      default:        disp_word = result_q;
    endcase
  end

  assign portA  = port_a_q;
  assign portB  = port_b_q;
  assign aluop  = aluop_q;
  assign exec   = exec_q;
  assign result = result_q;
  assign flags  = flags_q;
  assign stage  = state_q;

endmodule

// File: tb/tb_alu_input_seq.sv
module tb_alu_input_seq;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [16:0] sw;
  logic [3:0]  key_n;
  logic [31:0] alu_out;
  logic        alu_neg, alu_zero, alu_of;
  logic [31:0] portA, portB, result, disp_word;
  logic [3:0]  aluop;
  logic        exec;
  logic [2:0]  flags, stage;

  alu_input_seq #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .sw       (sw),
    .key_n    (key_n),
    .alu_out  (alu_out),
    .alu_neg  (alu_neg),
    .alu_zero (alu_zero),
    .alu_of   (alu_of),
    .portA    (portA),
    .portB    (portB),
    .aluop    (aluop),
    .exec     (exec),
    .result   (result),
    .flags    (flags),
    .stage    (stage),
    .disp_word(disp_word)
  );

  always #5 CLK = ~CLK;

  // Environment ALU: combinational, driven by the DUT operands.
  always_comb begin
    case (aluop)
      4'h2:    alu_out = portA + portB;
      4'h3:    alu_out = portA - portB;
      4'h4:    alu_out = portA & portB;
      4'h5:    alu_out = portA | portB;
      4'h6:    alu_out = portA ^ portB;
      default: alu_out = 32'h0;
    endcase
    alu_neg  = alu_out[31];
    alu_zero = (alu_out == 32'h0);
    if (aluop == 4'h2)      alu_of = (portA[31] == portB[31]) && (alu_out[31] != portA[31]);
    else if (aluop == 4'h3) alu_of = (portA[31] != portB[31]) && (alu_out[31] != portA[31]);
    else                    alu_of = 1'b0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state;  // 0 A, 1 B, 2 OP, 4 SHOW
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_op;
  logic [2:0]  m_flags;

  function automatic logic [31:0] sext_of(input logic [16:0] v);
    return {{16{v[16]}}, v[15:0]};
  endfunction

  task automatic model_reset();
    m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0;
  endtask

  task automatic model_exec();
    longint sa, sb, sr;
    logic   of;
    sa = longint'($signed(m_a));
    sb = longint'($signed(m_b));
    of = 1'b0;
    case (m_op)
      4'h2: begin sr = sa + sb; of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
      4'h3: begin sr = sa - sb; of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
      4'h4: sr = longint'(m_a & m_b);
      4'h5: sr = longint'(m_a | m_b);
      4'h6: sr = longint'(m_a ^ m_b);
      default: sr = 0;
    endcase
    m_res   = sr[31:0];
    m_flags = {of, m_res == 32'h0, m_res[31]};
    m_state = 4;
  endtask

  // mask bits: [0] enter [1] back [3] clear
  task automatic model_event(input logic [3:0] mask);
    if (mask[3]) begin
      model_reset();
    end else if (mask[1]) begin
      if (m_state == 1) m_state = 0;
      else if (m_state == 2) m_state = 1;
      else if (m_state == 4) m_state = 2;
    end else if (mask[0]) begin
      case (m_state)
        0: begin m_a = sext_of(sw); m_state = 1; end
        1: begin m_b = sext_of(sw); m_state = 2; end
        2: begin m_op = sw[3:0]; model_exec(); end
        4: m_state = 0;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] model_disp();
    if (m_state <= 1) return sext_of(sw);
    if (m_state == 2) return {28'b0, sw[3:0]};
    return m_res;
  endfunction

  // ---------------- per-cycle compare ----------------
  logic settled = 1'b0;
  int   exec_cnt = 0;
  int   chg_cnt = 0;
  logic [2:0] prev_stage = 3'd0;

  always @(negedge CLK) begin
    if (exec) exec_cnt++;
    if (nRST && stage != prev_stage) chg_cnt++;
    prev_stage = stage;
    if (settled && nRST) begin
      check("stage", {29'b0, stage}, m_state);
      check("portA", portA, m_a);
      check("portB", portB, m_b);
      check("aluop", {28'b0, aluop}, {28'b0, m_op});
      check("result", result, m_res);
      check("flags", {29'b0, flags}, {29'b0, m_flags});
      check("exec_idle", {31'b0, exec}, 32'h0);
      check("disp_word", disp_word, model_disp());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_sw(input logic [16:0] v);
    settled = 1'b0;
    @(negedge CLK);
    sw = v;
    repeat (3) @(negedge CLK);
    settled = 1'b1;
  endtask

  task automatic press(input logic [3:0] mask);
    settled = 1'b0;
    @(negedge CLK);
    key_n = ~mask;
    repeat (12) @(negedge CLK);
    key_n = 4'hF;
    repeat (12) @(negedge CLK);
    model_event(mask);
    settled = 1'b1;
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, "_portA"}, portA, 32'h0);
    check({tag, "_portB"}, portB, 32'h0);
    check({tag, "_aluop"}, {28'b0, aluop}, 32'h0);
    check({tag, "_result"}, result, 32'h0);
    check({tag, "_flags"}, {29'b0, flags}, 32'h0);
    check({tag, "_exec"}, {31'b0, exec}, 32'h0);
    check({tag, "_stage"}, {29'b0, stage}, 32'h0);
  endtask

  initial begin
    int  base;
    logic seen;
    nRST = 1'b0; sw = '0; key_n = 4'hF;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 check_zeroed("reset");
    @(negedge CLK);
    nRST = 1'b1;

    // Display tracks switches while idle.
    set_sw(17'h1_8000);
    check("disp_sext", disp_word, 32'hFFFF8000);

    // Full sequence: 5 + 3.
    set_sw(17'h0_0005); press(4'b0001);
    set_sw(17'h0_0003); press(4'b0001);
    set_sw(17'h0_0002);
    base = exec_cnt;
    press(4'b0001);
    check("exec_once", exec_cnt - base, 1);
    check("add_result", result, 32'h00000008);
    check("add_flags", {29'b0, flags}, 32'h0);
    check("show_stage", {29'b0, stage}, 32'h4);
    check("show_disp", disp_word, 32'h00000008);

    // Back from SHOW, rerun as SUB.
    press(4'b0010);
    check("back_stage", {29'b0, stage}, 32'h2);
    set_sw(17'h0_0003);
    press(4'b0001);
    check("sub_result", result, 32'h00000002);

    // Enter from SHOW keeps operands.
    press(4'b0001);
    check("retain_a", portA, 32'h5);

    // Bouncing enter, then a long hold.
    set_sw(17'h0_0009);
    settled = 1'b0;
    @(negedge CLK);
    chg_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      key_n[0] = ~key_n[0];
      repeat (2) @(negedge CLK);
    end
    key_n[0] = 1'b0;
    repeat (1000) @(negedge CLK);
    check("bounce_stage", {29'b0, stage}, 32'h1);
    check("bounce_changes", chg_cnt, 1);
    key_n = 4'hF;
    repeat (12) @(negedge CLK);
    model_event(4'b0001);
    settled = 1'b1;

    // Clear + back + enter together in LOAD_OP.
    press(4'b1000);
    set_sw(17'h0_0007);
    press(4'b0001); press(4'b0001);
    check("pre_simul_a", portA, 32'h7);
    base = exec_cnt;
    press(4'b1011);
    check("simul_stage", {29'b0, stage}, 32'h0);
    check("simul_a", portA, 32'h0);
    check("simul_noexec", exec_cnt - base, 0);

    // Back + enter together in LOAD_OP: back wins.
    set_sw(17'h0_0001);
    press(4'b0001); press(4'b0001);
    press(4'b0011);
    check("eb_stage", {29'b0, stage}, 32'h1);

    // Reset asserted during EXEC.
    press(4'b0001);
    settled = 1'b0;
    @(negedge CLK);
    key_n[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (exec) seen = 1'b1;
    end
    check("exec_seen", {31'b0, seen}, 32'h1);
    #2 nRST = 1'b0;
    #1 check_zeroed("rst_exec");
    key_n = 4'hF;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    chg_cnt = 0;
    repeat (20) @(negedge CLK);
    check("rst_exec_nochg", chg_cnt, 0);
    settled = 1'b1;

    // Reset during SHOW with a key mid-debounce.
    set_sw(17'h0_0005); press(4'b0001);
    set_sw(17'h0_0003); press(4'b0001);
    set_sw(17'h0_0002); press(4'b0001);
    check("pre_rst_show", result, 32'h8);
    settled = 1'b0;
    @(negedge CLK);
    key_n[1] = 1'b0;
    repeat (4) @(negedge CLK);
    #2 nRST = 1'b0;
    #1 check_zeroed("rst_show");
    key_n = 4'hF;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    chg_cnt = 0;
    repeat (20) @(negedge CLK);
    check("rst_show_nochg", chg_cnt, 0);
    check("rst_show_stage", {29'b0, stage}, 32'h0);
    settled = 1'b1;
    repeat (4) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
